// File: rtl/crg_rst_seq_if.sv
// rtl/crg_rst_seq_if.sv - channel control/status bundle for the clock/reset sequencer
//
// Purpose : groups the per-channel request/enable/reset signals and the
//           sequencer status so the sequencer and its user share one port.
// Signals : ch_en_req     per-channel clock-enable request (user -> sequencer)
//           ch_gce        BUFGCE clock enable per channel   (sequencer -> user)
//           ch_rst_n      active-low channel reset          (sequencer -> user)
//           ch_ready      ch_rst_n & ch_gce                 (sequencer -> user)
//           seq_state     sequencer FSM state               (sequencer -> user)
//           lock_lost_cnt saturating lock-loss count        (sequencer -> user)
interface crg_rst_seq_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] ch_en_req;
  logic [NUM_CH-1:0] ch_gce;
  logic [NUM_CH-1:0] ch_rst_n;
  logic [NUM_CH-1:0] ch_ready;
  logic [1:0]        seq_state;
  logic [7:0]        lock_lost_cnt;

  modport master (
    output ch_en_req,
    input  ch_gce, ch_rst_n, ch_ready, seq_state, lock_lost_cnt
  );

  modport slave (
    input  ch_en_req,
    output ch_gce, ch_rst_n, ch_ready, seq_state, lock_lost_cnt
  );
endinterface

// File: rtl/crg_rst_seq.sv
// rtl/crg_rst_seq.sv - PLL-lock driven staggered clock-enable/reset release sequencer
//
// Purpose : waits for a stable PLL lock, then releases channel clock enables
//           and resets one channel per GAP_CYC-cycle slot, runs with per-channel
//           enables, and drops everything for GAP_CYC cycles on lock loss.
// Ports   : clk_src    block clock (rising edge)
//           rst_n_sys  synchronous active-low reset
//           pll_locked PLL lock, asynchronous to clk_src (2-flop synchronized)
//           ctl        crg_rst_seq_if.slave channel control/status bundle
module crg_rst_seq #(
  parameter int NUM_CH          = 4,
  parameter int LOCK_STABLE_CYC = 64,
  parameter int GAP_CYC         = 16
) (
  input  logic          clk_src,
  input  logic          rst_n_sys,
  input  logic          pll_locked,
  crg_rst_seq_if.slave  ctl
);

  localparam int STB_W  = $clog2(LOCK_STABLE_CYC + 1);
  localparam int GAP_W  = $clog2(GAP_CYC + 1);
  localparam int SLOT_W = $clog2(NUM_CH + 1);

  localparam logic [STB_W-1:0]  STB_LAST  = STB_W'(LOCK_STABLE_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_RELEASE   = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_lock_meta;
  logic                r_lock_s;
  logic [STB_W-1:0]    r_stable;
  logic [GAP_W-1:0]    r_gap;
  logic [SLOT_W-1:0]   r_slot;
  logic [NUM_CH-1:0]   r_gce;
  logic [NUM_CH-1:0]   r_rst_n;
  logic [NUM_CH-1:0]   r_ready;
  logic [7:0]          r_lost;

  logic [NUM_CH-1:0]   w_slot_oh;
  logic                w_lock_lost;

  // One-hot of the channel owning the current release slot.
  assign w_slot_oh   = NUM_CH'(1) << r_slot;
  // Lock loss only matters once channels may be running.
  assign w_lock_lost = !r_lock_s && (r_state == ST_RELEASE || r_state == ST_RUN);

  always_ff @(posedge clk_src) begin
    if (!rst_n_sys) begin
      r_state     <= ST_WAIT_LOCK;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_stable    <= '0;
      r_gap       <= '0;
      r_slot      <= '0;
      r_gce       <= '0;
      r_rst_n     <= '0;
      r_ready     <= '0;
      r_lost      <= '0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;

      if (w_lock_lost) begin
        // Lock loss wins over every other transition, including RELEASE->RUN.
        r_state  <= ST_FAULT;
        r_gce    <= '0;
        r_rst_n  <= '0;
        r_ready  <= '0;
        r_stable <= '0;
        r_gap    <= '0;
        r_slot   <= '0;
        if (r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
      end else begin
        case (r_state)
          ST_WAIT_LOCK: begin
            r_gce   <= '0;
            r_rst_n <= '0;
            r_ready <= '0;
            if (!r_lock_s) begin
              r_stable <= '0;
            end else if (r_stable == STB_LAST) begin
              r_stable <= '0;
              r_gap    <= '0;
              r_slot   <= '0;
              r_state  <= ST_RELEASE;
            end else begin
              r_stable <= r_stable + STB_W'(1);
            end
          end

          ST_RELEASE: begin
            // Bits only ever get set here, so serviced channels stay enabled.
            if (r_gap == '0) r_gce <= r_gce | w_slot_oh;
            if (r_gap == GAP_LAST) begin
              // Clock has been running for the whole slot; ready follows reset.
              r_rst_n <= r_rst_n | w_slot_oh;
              r_ready <= r_ready | w_slot_oh;
              r_gap   <= '0;
              if (r_slot == SLOT_LAST) begin
                r_slot  <= '0;
                r_state <= ST_RUN;
              end else begin
                r_slot <= r_slot + SLOT_W'(1);
              end
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end

          ST_RUN: begin
            r_rst_n <= '1;
            r_gce   <= ctl.ch_en_req;
            r_ready <= ctl.ch_en_req;
          end

          ST_FAULT: begin
            r_gce   <= '0;
            r_rst_n <= '0;
            r_ready <= '0;
            if (r_gap == GAP_LAST) begin
              r_gap   <= '0;
              r_state <= ST_WAIT_LOCK;
            end else begin
              r_gap <= r_gap + GAP_W'(1);
            end
          end

          default: r_state <= ST_WAIT_LOCK;
        endcase
      end
    end
  end

  assign ctl.ch_gce        = r_gce;
  assign ctl.ch_rst_n      = r_rst_n;
  assign ctl.ch_ready      = r_ready;
  assign ctl.seq_state     = r_state;
  assign ctl.lock_lost_cnt = r_lost;

endmodule

// File: tb/tb_crg_rst_seq.sv
// tb/tb_crg_rst_seq.sv - directed self-checking bench for crg_rst_seq
module tb_crg_rst_seq;

  logic clk_src = 1'b0;
  logic rst_n_sys;
  logic pll_locked;
  int   n_chk = 0;
  int   n_err = 0;

  crg_rst_seq_if #(.NUM_CH(4)) u_if ();

  crg_rst_seq #(
    .NUM_CH          (4),
    .LOCK_STABLE_CYC (8),
    .GAP_CYC         (4)
  ) u_dut (
    .clk_src    (clk_src),
    .rst_n_sys  (rst_n_sys),
    .pll_locked (pll_locked),
    .ctl        (u_if)
  );

  always #5 clk_src = ~clk_src;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_src);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (u_if.seq_state !== s && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_state", 32'(u_if.seq_state), 32'(s));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gce"},   32'(u_if.ch_gce),   32'h0);
    check({tag, "_rst_n"}, 32'(u_if.ch_rst_n), 32'h0);
    check({tag, "_ready"}, 32'(u_if.ch_ready), 32'h0);
  endtask

  // n = edges from now until RELEASE becomes visible; lock high, ch_en_req = F.
  task automatic seq_check(input int n);
    tick(n - 1);
    check("pre_rel_state", 32'(u_if.seq_state), 32'd0);
    check_all_zero("pre_rel");
    tick(1);
    check("rel_state", 32'(u_if.seq_state), 32'd1);
    check("rel_gce0", 32'(u_if.ch_gce), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("slot_gce",   32'(u_if.ch_gce),   (32'd1 << (k + 1)) - 1);
      check("slot_rst_a", 32'(u_if.ch_rst_n), (32'd1 << k) - 1);
      tick(3);
      check("slot_rst_b", 32'(u_if.ch_rst_n), (32'd1 << (k + 1)) - 1);
      check("slot_ready", 32'(u_if.ch_ready), (32'd1 << (k + 1)) - 1);
      check("slot_state", 32'(u_if.seq_state), (k == 3) ? 32'd2 : 32'd1);
    end
    tick(1);
    check("run_gce",   32'(u_if.ch_gce),   32'hF);
    check("run_ready", 32'(u_if.ch_ready), 32'hF);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_sys      = 1'b0;
    pll_locked     = 1'b1;
    u_if.ch_en_req = 4'hF;
    tick(2);
    check("rst_state", 32'(u_if.seq_state), 32'd0);
    check("rst_lost",  32'(u_if.lock_lost_cnt), 32'd0);
    check_all_zero("rst");

    // Lock glitch: locked_s low at the edge that would make stable count 7.
    rst_n_sys = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    seq_check(10);
    check("glitch_lost", 32'(u_if.lock_lost_cnt), 32'd0);

    u_if.ch_en_req = 4'h5;
    tick(1);
    check("en5_gce",   32'(u_if.ch_gce),   32'h5);
    check("en5_rst_n", 32'(u_if.ch_rst_n), 32'hF);
    check("en5_ready", 32'(u_if.ch_ready), 32'h5);
    u_if.ch_en_req = 4'hF;
    tick(1);

    // Lock drop in RUN: two sync edges, then FAULT.
    pll_locked = 1'b0;
    tick(2);
    check("drop_still_run", 32'(u_if.seq_state), 32'd2);
    tick(1);
    check("fault_state", 32'(u_if.seq_state), 32'd3);
    check("fault_lost",  32'(u_if.lock_lost_cnt), 32'd1);
    check_all_zero("fault");
    pll_locked = 1'b1;
    tick(3);
    check("fault_hold", 32'(u_if.seq_state), 32'd3);
    tick(1);
    check("fault_exit", 32'(u_if.seq_state), 32'd0);
    seq_check(8);

    // Repeated lock loss: the counter saturates rather than wrapping.
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      wait_state(2'd3, 16);
      pll_locked = 1'b1;
      wait_state(2'd1, 64);
      if (i == 98) check("lost_100", 32'(u_if.lock_lost_cnt), 32'd100);
    end
    check("lost_sat", 32'(u_if.lock_lost_cnt), 32'hFF);

    // Reset mid-RELEASE, coinciding with lock loss.
    rst_n_sys = 1'b0;
    tick(1);
    check("rst2_lost", 32'(u_if.lock_lost_cnt), 32'd0);
    rst_n_sys = 1'b1;
    tick(10);
    check("rst2_rel", 32'(u_if.seq_state), 32'd1);
    tick(7);
    check("slot1_gce",   32'(u_if.ch_gce),   32'h3);
    check("slot1_rst_n", 32'(u_if.ch_rst_n), 32'h1);
    pll_locked = 1'b0;
    tick(2);
    rst_n_sys = 1'b0;
    tick(1);
    check("mid_rst_state", 32'(u_if.seq_state), 32'd0);
    check("mid_rst_lost",  32'(u_if.lock_lost_cnt), 32'd0);
    check_all_zero("mid_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/crg_rst_seq.md
CRG_RST_SEQ -- requirements
Module: crg_rst_seq

Interface
REQ-001 NUM_CH, 4, number of gated clock/reset channels (1..16).
REQ-002 LOCK_STABLE_CYC, 64, consecutive synchronized-locked cycles required before release (2..65535).
REQ-003 GAP_CYC, 16, cycles per channel release slot (2..255).
REQ-004 clk_src  input  1  single block clock; all logic on rising edge.
REQ-005 rst_n_sys  input  1  reset, synchronous and active-low.
REQ-006 pll_locked  input  1  MMCM/PLL lock, asynchronous to clk_src.
REQ-007 ch_en_req  input  NUM_CH  per-channel clock-enable request, honoured in RUN only.
REQ-008 ch_gce  output  NUM_CH  registered BUFGCE CE per channel.
REQ-009 ch_rst_n  output  NUM_CH  registered active-low channel reset.
REQ-010 ch_ready  output  NUM_CH  ch_rst_n[i] & ch_gce[i], registered.
REQ-011 seq_state  output  2  current FSM state encoding.
REQ-012 lock_lost_cnt  output  8  saturating count of lock-loss events.

Function
REQ-013 pll_locked SHALL pass through a 2-flop synchronizer (locked_s) before any use; no other input is synchronized.
REQ-014 FSM states SHALL be WAIT_LOCK=0, RELEASE=1, RUN=2, FAULT=3; seq_state reflects the registered state.
REQ-015 WAIT_LOCK: stable counter increments each cycle locked_s=1, clears to 0 on locked_s=0; all ch_rst_n=0, ch_gce=0.
REQ-016 WAIT_LOCK -> RELEASE on the cycle the counter completes LOCK_STABLE_CYC consecutive locked_s=1 cycles.
REQ-017 RELEASE: channels serviced in ascending index, one slot of GAP_CYC cycles each; slot k spans RELEASE cycles k*GAP_CYC .. k*GAP_CYC+GAP_CYC-1.
REQ-018 In slot k, ch_gce[k] SHALL rise at slot offset 0 and ch_rst_n[k] SHALL rise at slot offset GAP_CYC-1 (registered outputs, visible the following cycle).
REQ-019 During RELEASE ch_gce of already-serviced channels SHALL stay 1 regardless of ch_en_req; unserviced channels stay ch_gce=0, ch_rst_n=0.
REQ-020 RELEASE -> RUN after slot NUM_CH-1 completes (NUM_CH*GAP_CYC cycles in RELEASE).
REQ-021 RUN: ch_rst_n all 1; ch_gce[i] SHALL follow ch_en_req[i] with 1-cycle latency.
REQ-022 locked_s=0 in RELEASE or RUN SHALL enter FAULT next cycle; on FAULT entry all ch_gce=0 and ch_rst_n=0 in the same registered update, slot and stable counters clear.
REQ-023 Each RELEASE/RUN->FAULT transition SHALL increment lock_lost_cnt by 1, saturating at 255 (no wrap).
REQ-024 FAULT SHALL last exactly GAP_CYC cycles, then WAIT_LOCK, regardless of locked_s during FAULT.
REQ-025 locked_s=0 on the same cycle RELEASE would finish SHALL take FAULT; lock loss has priority over every other transition.
REQ-026 Counters SHALL be sized $clog2 of their maximum +1; no arithmetic overflow at parameter maxima.

Reset
REQ-027 rst_n_sys=0 sampled at a clk_src edge SHALL, at that edge: state=WAIT_LOCK, all counters 0, synchronizer flops 0, ch_gce=0, ch_rst_n=0, ch_ready=0, lock_lost_cnt=0.
REQ-028 Reset asserted mid-RELEASE or RUN SHALL override lock loss and not increment lock_lost_cnt.
REQ-029 No output SHALL be X after the first reset edge.

Verification (NUM_CH=4, LOCK_STABLE_CYC=8, GAP_CYC=4)
REQ-030 Lock held high from reset release -> RELEASE entered after 2 sync + 8 stable cycles; ch_rst_n rises in order 0,1,2,3 at RELEASE cycles 3,7,11,15 (+1 register); RUN at cycle 16; ch_ready=4'hF with ch_en_req=4'hF.
REQ-031 Lock glitch low 1 cycle at stable count 6 -> counter clears; RELEASE delayed by full 8 further cycles; lock_lost_cnt stays 0.
REQ-032 Lock drop during RUN -> next cycle FAULT, all outputs 0, lock_lost_cnt=1; 4 cycles later WAIT_LOCK; relock yields full sequence again.
REQ-033 In RUN toggle ch_en_req 4'hF -> 4'h5 -> ch_gce=4'h5 one cycle later, ch_rst_n stays 4'hF, ch_ready=4'h5.
REQ-034 300 forced lock-loss events -> lock_lost_cnt saturates at 8'hFF.
REQ-035 rst_n_sys=0 during slot 2 of RELEASE -> next edge all outputs 0, seq_state=0, lock_lost_cnt unchanged from reset value 0.
